// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - RISC-V write-back stage: load extraction, result select, regfile write, instret
module mem_wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_w,
  input  logic            flush_w,
  input  logic            valid_M,
  input  logic            RegWrite_M,
  input  logic [4:0]      rd_M,
  input  logic [1:0]      ResultSrc_M,
  input  logic [2:0]      funct3_M,
  input  logic [XLEN-1:0] ALUResult_M,
  input  logic [XLEN-1:0] ReadData_M,
  input  logic [XLEN-1:0] PCPlus4_M,
  output logic            RegWrite_W,
  output logic [4:0]      rd_w,
  output logic [XLEN-1:0] write_data,
  output logic            valid_W,
  output logic            load_fault_W,
  output logic [63:0]     instret
);

  logic            r_valid;
  logic            r_regwrite;
  logic [4:0]      r_rd;
  logic [1:0]      r_result_src;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_alu_result;
  logic [XLEN-1:0] r_read_data;
  logic [XLEN-1:0] r_pcplus4;
  logic [63:0]     r_instret;

  logic [1:0]      w_off;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load_data;
  logic            w_load_bad;
  logic            w_fault;
  logic [XLEN-1:0] w_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_regwrite   <= 1'b0;
      r_rd         <= '0;
      r_result_src <= '0;
      r_funct3     <= '0;
      r_alu_result <= '0;
      r_read_data  <= '0;
      r_pcplus4    <= '0;
    end else if (flush_w) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
    end else if (!stall_w) begin
      r_valid      <= valid_M;
      r_regwrite   <= RegWrite_M;
      r_rd         <= rd_M;
      r_result_src <= ResultSrc_M;
      r_funct3     <= funct3_M;
      r_alu_result <= ALUResult_M;
      r_read_data  <= ReadData_M;
      r_pcplus4    <= PCPlus4_M;
    end
  end

  // An instruction is counted once, on the edge where it leaves WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (r_valid && !stall_w) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign w_off  = r_alu_result[1:0];
  assign w_half = w_off[1] ? r_read_data[31:16] : r_read_data[15:0];

  always_comb begin
    w_byte = r_read_data[7:0];
    case (w_off)
      2'd0: w_byte = r_read_data[7:0];
      2'd1: w_byte = r_read_data[15:8];
      2'd2: w_byte = r_read_data[23:16];
      2'd3: w_byte = r_read_data[31:24];
      default: w_byte = r_read_data[7:0];
    endcase
  end

  always_comb begin
    w_load_data = '0;
    w_load_bad  = 1'b0;
    case (r_funct3)
      3'b000: w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100: w_load_data = {24'd0, w_byte};
      3'b001: begin
        w_load_data = {{16{w_half[15]}}, w_half};
        w_load_bad  = w_off[0];
      end
      3'b101: begin
        w_load_data = {16'd0, w_half};
        w_load_bad  = w_off[0];
      end
      3'b010: begin
        w_load_data = r_read_data;
        w_load_bad  = (w_off != 2'd0);
      end
      default: w_load_bad = 1'b1;
    endcase
  end

  always_comb begin
    case (r_result_src)
      2'b01:   w_result = w_load_data;
      2'b10:   w_result = r_pcplus4;
      default: w_result = r_alu_result;
    endcase
  end

  assign w_fault      = r_valid && (r_result_src == 2'b01) && w_load_bad;
  assign load_fault_W = w_fault;
  assign RegWrite_W   = r_valid && r_regwrite && (r_rd != 5'd0) && !w_fault;
  assign rd_w         = r_rd;
  assign write_data   = w_fault ? '0 : w_result;
  assign valid_W      = r_valid;
  assign instret      = r_instret;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_w, flush_w, valid_M, RegWrite_M;
  logic [4:0]  rd_M;
  logic [1:0]  ResultSrc_M;
  logic [2:0]  funct3_M;
  logic [31:0] ALUResult_M, ReadData_M, PCPlus4_M;
  logic        RegWrite_W, valid_W, load_fault_W;
  logic [4:0]  rd_w;
  logic [31:0] write_data;
  logic [63:0] instret;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_instret;
  logic        exp_valid_w;

  mem_wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall_w(stall_w), .flush_w(flush_w),
    .valid_M(valid_M), .RegWrite_M(RegWrite_M), .rd_M(rd_M),
    .ResultSrc_M(ResultSrc_M), .funct3_M(funct3_M), .ALUResult_M(ALUResult_M),
    .ReadData_M(ReadData_M), .PCPlus4_M(PCPlus4_M), .RegWrite_W(RegWrite_W),
    .rd_w(rd_w), .write_data(write_data), .valid_W(valid_W),
    .load_fault_W(load_fault_W), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected counter/valid evolve from the inputs presented at each edge.
  task automatic step();
    if (rst_n) begin
      if (exp_valid_w && !stall_w) exp_instret = exp_instret + 64'd1;
      if (flush_w) exp_valid_w = 1'b0;
      else if (!stall_w) exp_valid_w = valid_M;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] rs, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc);
    valid_M = v; RegWrite_M = rw; rd_M = rd; ResultSrc_M = rs;
    funct3_M = f3; ALUResult_M = alu; PCPlus4_M = pc;
  endtask

  logic [2:0]  ld_f3  [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [31:0] ld_adr [6] = '{32'h1001, 32'h1002, 32'h1003, 32'h1002, 32'h1000, 32'h1000};
  logic [31:0] ld_exp [6] = '{32'h0000007F, 32'hFFFFFFF1, 32'h00000080,
                              32'hFFFF80F1, 32'h00007F02, 32'h80F17F02};
  logic [2:0]  ft_f3  [3] = '{3'b010, 3'b001, 3'b011};
  logic [31:0] ft_adr [3] = '{32'h2002, 32'h2001, 32'h2000};

  initial begin
    exp_instret = '0;
    exp_valid_w = 1'b0;
    rst_n = 1'b0; stall_w = 1'b0; flush_w = 1'b0;
    ReadData_M = 32'hDEADBEEF;
    drive(1'b1, 1'b1, 5'd9, 2'b00, 3'b000, 32'hCAFE, 32'h44);
    repeat (3) step();
    check("rst_regwrite", {63'd0, RegWrite_W}, 64'd0);
    check("rst_rd", {59'd0, rd_w}, 64'd0);
    check("rst_wdata", {32'd0, write_data}, 64'd0);
    check("rst_valid", {63'd0, valid_W}, 64'd0);
    check("rst_fault", {63'd0, load_fault_W}, 64'd0);
    check("rst_instret", instret, 64'd0);

    rst_n = 1'b1;
    drive(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 32'h1234, 32'h0);
    step();
    check("first_regwrite", {63'd0, RegWrite_W}, 64'd1);
    check("first_rd", {59'd0, rd_w}, 64'd5);
    check("first_wdata", {32'd0, write_data}, 64'h1234);
    check("first_instret", instret, 64'd0);

    ReadData_M = 32'h80F17F02;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 5'd3, 2'b01, ld_f3[i], ld_adr[i], 32'h0);
      step();
      check($sformatf("load%0d_wdata", i), {32'd0, write_data}, {32'd0, ld_exp[i]});
      check($sformatf("load%0d_we", i), {63'd0, RegWrite_W}, 64'd1);
      check($sformatf("load%0d_instret", i), instret, exp_instret);
    end

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'd7, 2'b01, ft_f3[i], ft_adr[i], 32'h0);
      step();
      check($sformatf("fault%0d_flag", i), {63'd0, load_fault_W}, 64'd1);
      check($sformatf("fault%0d_we", i), {63'd0, RegWrite_W}, 64'd0);
      check($sformatf("fault%0d_wdata", i), {32'd0, write_data}, 64'd0);
      check($sformatf("fault%0d_rd", i), {59'd0, rd_w}, 64'd7);
    end
    drive(1'b1, 1'b1, 5'd0, 2'b00, 3'b011, 32'h55, 32'h0);
    step();
    check("fault_counted", instret, exp_instret);
    check("x0_we", {63'd0, RegWrite_W}, 64'd0);
    check("x0_valid", {63'd0, valid_W}, 64'd1);
    check("alu_f3_011_nofault", {63'd0, load_fault_W}, 64'd0);

    drive(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'h9999, 32'h104);
    step();
    check("link_wdata", {32'd0, write_data}, 64'h104);
    check("link_we", {63'd0, RegWrite_W}, 64'd1);

    drive(1'b1, 1'b1, 5'd6, 2'b11, 3'b000, 32'hABCD, 32'h200);
    step();
    check("rsv_wdata", {32'd0, write_data}, 64'hABCD);

    stall_w = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'(10 + i), 2'b10, 3'b000, 32'h3000 + i, 32'h400 + i);
      step();
      check($sformatf("stall%0d_wdata", i), {32'd0, write_data}, 64'hABCD);
      check($sformatf("stall%0d_rd", i), {59'd0, rd_w}, 64'd6);
      check($sformatf("stall%0d_instret", i), instret, exp_instret);
    end
    stall_w = 1'b0;
    drive(1'b1, 1'b1, 5'd2, 2'b00, 3'b000, 32'h77, 32'h0);
    step();
    check("unstall_wdata", {32'd0, write_data}, 64'h77);
    check("unstall_instret", instret, exp_instret);

    flush_w = 1'b1; stall_w = 1'b1;
    step();
    check("flush_valid", {63'd0, valid_W}, 64'd0);
    check("flush_we", {63'd0, RegWrite_W}, 64'd0);
    check("flush_instret", instret, exp_instret);
    flush_w = 1'b0; stall_w = 1'b0;
    drive(1'b1, 1'b1, 5'd4, 2'b00, 3'b000, 32'h9, 32'h0);
    step();
    check("postflush_instret", instret, exp_instret);
    check("postflush_wdata", {32'd0, write_data}, 64'h9);

    stall_w = 1'b1;
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instret;
    #1;
    check("wrap_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    stall_w = 1'b0;
    step();
    check("wrap_zero", instret, 64'd0);
    check("wrap_model", instret, exp_instret);

    rst_n = 1'b0;
    exp_valid_w = 1'b0;
    exp_instret = '0;
    #1;
    check("midrst_we", {63'd0, RegWrite_W}, 64'd0);
    check("midrst_valid", {63'd0, valid_W}, 64'd0);
    check("midrst_instret", instret, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
